// File: rtl/seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_decoder
// Description : Receive-side checker for a two-digit multiplexed 7-segment
//               bus. Tracks digit-select alternation, decodes the segment
//               patterns, and publishes a tens/units BCD pair once the same
//               legal frame has been seen STABLE_FRAMES times in a row.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_decoder #(
    parameter int STABLE_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] segments,
    input  logic       digit,
    output logic [3:0] ten_count,
    output logic [3:0] unit_count,
    output logic       valid,
    output logic       locked,
    output logic       err_pattern,
    output logic       err_digit
);

    localparam logic [3:0] C_STABLE = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        HUNT        = 2'd0,
        EXPECT_TEN  = 2'd1,
        EXPECT_UNIT = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [3:0] r_unit_val;
    logic       r_unit_legal;
    logic [3:0] r_cand_ten;
    logic [3:0] r_cand_unit;
    logic [3:0] r_match;

    logic [3:0] w_seg_val;
    logic       w_seg_legal;
    logic       w_capture_unit;
    logic       w_frame_done;
    logic       w_err_digit;
    logic       w_frame_legal;
    logic       w_same;
    logic [3:0] w_match_next;
    logic       w_publish;

    // Exact-match decode of the current segment bus; anything else is illegal.
    always_comb begin
        w_seg_val   = 4'd0;
        w_seg_legal = 1'b1;
        case (segments)
            7'b0111111: w_seg_val = 4'd0;
            7'b0000110: w_seg_val = 4'd1;
            7'b1011011: w_seg_val = 4'd2;
            7'b1001111: w_seg_val = 4'd3;
            7'b1100110: w_seg_val = 4'd4;
            7'b1101101: w_seg_val = 4'd5;
            7'b1111100: w_seg_val = 4'd6;
            7'b0000111: w_seg_val = 4'd7;
            7'b1111111: w_seg_val = 4'd8;
            7'b1100111: w_seg_val = 4'd9;
            default:    w_seg_legal = 1'b0;
        endcase
    end

    // Digit-select sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-sample control strobes for the sequencer.
    always_comb begin
        w_state_next   = r_state;
        w_capture_unit = 1'b0;
        w_frame_done   = 1'b0;
        w_err_digit    = 1'b0;
        case (r_state)
            HUNT: begin
                // A tens sample before any units sample is simply ignored.
                if (!digit) begin
                    w_capture_unit = 1'b1;
                    w_state_next   = EXPECT_TEN;
                end
            end
            EXPECT_TEN: begin
                if (digit) begin
                    w_frame_done = 1'b1;
                    w_state_next = EXPECT_UNIT;
                end else begin
                    // Repeated units sample: newest one wins.
                    w_err_digit    = 1'b1;
                    w_capture_unit = 1'b1;
                end
            end
            EXPECT_UNIT: begin
                if (!digit) begin
                    w_capture_unit = 1'b1;
                    w_state_next   = EXPECT_TEN;
                end else begin
                    w_err_digit  = 1'b1;
                    w_state_next = HUNT;
                end
            end
            default: w_state_next = HUNT;
        endcase
    end

    // Frame evaluation: legality, candidate comparison and stability count.
    always_comb begin
        w_frame_legal = r_unit_legal & w_seg_legal;
        w_same        = (w_seg_val == r_cand_ten) && (r_unit_val == r_cand_unit);
        if (!w_same) begin
            w_match_next = 4'd1;
        end else if (r_match >= C_STABLE) begin
            w_match_next = C_STABLE;
        end else begin
            w_match_next = r_match + 4'd1;
        end
        // A replaced candidate always counts as a fresh arrival at the
        // threshold, which only matters when a single frame suffices.
        w_publish = w_frame_done && w_frame_legal && (w_match_next == C_STABLE)
                    && (!w_same || (r_match != C_STABLE));
    end

    // Datapath: unit capture, candidate tracking, published outputs and pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_unit_val   <= 4'd0;
            r_unit_legal <= 1'b0;
            r_cand_ten   <= 4'd0;
            r_cand_unit  <= 4'd0;
            r_match      <= 4'd0;
            ten_count    <= 4'd0;
            unit_count   <= 4'd0;
            valid        <= 1'b0;
            locked       <= 1'b0;
            err_pattern  <= 1'b0;
            err_digit    <= 1'b0;
        end else begin
            valid       <= 1'b0;
            err_pattern <= 1'b0;
            err_digit   <= w_err_digit;
            if (w_err_digit) begin
                locked <= 1'b0;
            end
            if (w_capture_unit) begin
                r_unit_val   <= w_seg_val;
                r_unit_legal <= w_seg_legal;
            end
            if (w_frame_done) begin
                if (!w_frame_legal) begin
                    err_pattern <= 1'b1;
                    locked      <= 1'b0;
                    r_match     <= 4'd0;
                end else begin
                    r_cand_ten  <= w_seg_val;
                    r_cand_unit <= r_unit_val;
                    r_match     <= w_match_next;
                    if (w_publish) begin
                        ten_count  <= w_seg_val;
                        unit_count <= r_unit_val;
                        valid      <= 1'b1;
                        locked     <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_decoder
// Description : Self-checking bench for seven_segment_decoder. Two instances
//               (STABLE_FRAMES = 2 and 1) share one stimulus stream and are
//               compared each cycle against a frame-level reference model,
//               plus a directed vector table and an alternating-value sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_decoder;

    logic       clk;
    logic       reset;
    logic [6:0] segments;
    logic       digit;

    logic [3:0] ten2, unit2, ten1, unit1;
    logic       valid2, locked2, ep2, ed2;
    logic       valid1, locked1, ep1, ed1;

    seven_segment_decoder #(.STABLE_FRAMES(2)) dut2 (
        .clk(clk), .reset(reset), .segments(segments), .digit(digit),
        .ten_count(ten2), .unit_count(unit2), .valid(valid2), .locked(locked2),
        .err_pattern(ep2), .err_digit(ed2)
    );

    seven_segment_decoder #(.STABLE_FRAMES(1)) dut1 (
        .clk(clk), .reset(reset), .segments(segments), .digit(digit),
        .ten_count(ten1), .unit_count(unit1), .valid(valid1), .locked(locked1),
        .err_pattern(ep1), .err_digit(ed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Glyph table and its inverse (-1 marks an illegal pattern).
    logic [6:0] enc [10];
    int         lut [128];

    // Reference model state, expressed in terms of frames and integer values.
    typedef struct packed {
        bit have_u;   // a units sample is waiting for its tens partner
        int u;        // decoded waiting units digit, -1 if illegal
        bit synced;   // at least one units sample seen since last sync loss
        int cand;     // candidate value, 0..99
        int cnt;      // consecutive matching frames
        int ten;
        int unit;
        bit valid;
        bit locked;
        bit ep;
        bit ed;
    } mstate_t;

    mstate_t m2, m1;

    function automatic mstate_t mstep(mstate_t s, bit rst, logic [6:0] seg, bit dig, int n);
        mstate_t r;
        int      v, val, newc;
        bit      changed;
        r = s;
        r.valid = 1'b0;
        r.ep    = 1'b0;
        r.ed    = 1'b0;
        if (rst) begin
            r = '0;
            return r;
        end
        v = lut[seg];
        if (!dig) begin
            if (s.have_u) begin
                r.ed     = 1'b1;
                r.locked = 1'b0;
            end
            r.have_u = 1'b1;
            r.u      = v;
            r.synced = 1'b1;
        end else if (s.have_u) begin
            r.have_u = 1'b0;
            if (v < 0 || s.u < 0) begin
                r.ep     = 1'b1;
                r.locked = 1'b0;
                r.cnt    = 0;
            end else begin
                val     = v * 10 + s.u;
                changed = (val != s.cand);
                newc    = changed ? 1 : ((s.cnt + 1 > n) ? n : s.cnt + 1);
                r.cand  = val;
                if (newc == n && (changed || s.cnt != n)) begin
                    r.ten    = val / 10;
                    r.unit   = val % 10;
                    r.valid  = 1'b1;
                    r.locked = 1'b1;
                end
                r.cnt = newc;
            end
        end else if (s.synced) begin
            r.ed     = 1'b1;
            r.locked = 1'b0;
            r.synced = 1'b0;
        end
        return r;
    endfunction

    function automatic logic [11:0] mvec(mstate_t s);
        return {4'(s.ten), 4'(s.unit), s.valid, s.locked, s.ep, s.ed};
    endfunction

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h (ten,unit,valid,locked,err_pattern,err_digit)",
                     name, act, exp);
        end
    endtask

    // Apply one sample, advance the models, and compare both DUTs after the edge.
    task automatic step(input bit rst, input logic [6:0] seg, input bit dig);
        reset    = rst;
        segments = seg;
        digit    = dig;
        m2 = mstep(m2, rst, seg, dig, 2);
        m1 = mstep(m1, rst, seg, dig, 1);
        @(posedge clk);
        #1;
        check("model_n2", {ten2, unit2, valid2, locked2, ep2, ed2}, mvec(m2));
        check("model_n1", {ten1, unit1, valid1, locked1, ep1, ed1}, mvec(m1));
    endtask

    typedef struct packed {
        bit         rst;
        logic [6:0] seg;
        bit         dig;
        logic [3:0] ten;
        logic [3:0] unit;
        bit         valid;
        bit         locked;
        bit         ep;
        bit         ed;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rst, input logic [6:0] seg, input bit dig,
                       input int ten, input int unit,
                       input bit v, input bit l, input bit ep, input bit ed);
        tbl.push_back({rst, seg, dig, 4'(ten), 4'(unit), v, l, ep, ed});
    endtask

    localparam logic [6:0] BL = 7'b0000000;

    initial begin
        vec_t       t;
        int         val, nextd, d;
        bit         rst;
        logic [6:0] seg;

        reset    = 1'b1;
        segments = '0;
        digit    = 1'b0;
        m2       = '0;
        m1       = '0;

        enc[0] = 7'b0111111; enc[1] = 7'b0000110; enc[2] = 7'b1011011;
        enc[3] = 7'b1001111; enc[4] = 7'b1100110; enc[5] = 7'b1101101;
        enc[6] = 7'b1111100; enc[7] = 7'b0000111; enc[8] = 7'b1111111;
        enc[9] = 7'b1100111;
        for (int i = 0; i < 128; i++) lut[i] = -1;
        for (int i = 0; i < 10; i++) lut[enc[i]] = i;

        // Directed vectors for the STABLE_FRAMES=2 instance.
        //   rst seg     dig ten unit valid locked ep ed
        add(1, BL,     0, 0, 0, 0, 0, 0, 0);  // reset state
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(0, enc[4], 1, 0, 0, 0, 0, 0, 0);  // frame 1 of 42
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(0, enc[4], 1, 4, 2, 1, 1, 0, 0);  // frame 2 -> publish
        add(0, enc[2], 0, 4, 2, 0, 1, 0, 0);
        add(0, enc[4], 1, 4, 2, 0, 1, 0, 0);  // saturated, no pulse
        add(0, BL,     0, 4, 2, 0, 1, 0, 0);
        add(0, enc[4], 1, 4, 2, 0, 0, 1, 0);  // blank units -> err_pattern
        add(0, enc[2], 0, 4, 2, 0, 0, 0, 0);
        add(0, enc[4], 1, 4, 2, 0, 0, 0, 0);
        add(0, enc[2], 0, 4, 2, 0, 0, 0, 0);
        add(0, enc[4], 1, 4, 2, 1, 1, 0, 0);  // relocked
        add(0, enc[2], 0, 4, 2, 0, 1, 0, 0);
        add(0, enc[2], 0, 4, 2, 0, 0, 0, 1);  // 0,0 -> err_digit
        add(0, enc[4], 1, 4, 2, 0, 0, 0, 0);  // frame completes, count saturated
        add(0, enc[6], 0, 4, 2, 0, 0, 0, 0);
        add(0, enc[9], 1, 4, 2, 0, 0, 0, 0);  // 96 first frame
        add(0, enc[6], 0, 4, 2, 0, 0, 0, 0);
        add(0, enc[9], 1, 9, 6, 1, 1, 0, 0);  // 96 second frame -> publish
        add(0, enc[6], 0, 9, 6, 0, 1, 0, 0);
        add(0, enc[9], 1, 9, 6, 0, 1, 0, 0);
        add(0, enc[9], 1, 9, 6, 0, 0, 0, 1);  // 1,1 -> err_digit, back to hunt
        add(0, enc[6], 0, 9, 6, 0, 0, 0, 0);
        add(0, enc[9], 1, 9, 6, 0, 0, 0, 0);  // fresh frame accepted, cnt saturated
        add(1, BL,     0, 0, 0, 0, 0, 0, 0);
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(0, enc[4], 1, 0, 0, 0, 0, 0, 0);
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(1, enc[2], 0, 0, 0, 0, 0, 0, 0);  // reset mid-frame
        add(0, enc[4], 1, 0, 0, 0, 0, 0, 0);  // tens in hunt ignored
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(0, enc[4], 1, 0, 0, 0, 0, 0, 0);
        add(0, enc[2], 0, 0, 0, 0, 0, 0, 0);
        add(0, enc[4], 1, 4, 2, 1, 1, 0, 0);

        foreach (tbl[i]) begin
            t = tbl[i];
            step(t.rst, t.seg, t.dig);
            check($sformatf("table[%0d]", i), {ten2, unit2, valid2, locked2, ep2, ed2},
                  {t.ten, t.unit, t.valid, t.locked, t.ep, t.ed});
        end

        // STABLE_FRAMES=1: alternating 13 / 57 publishes on every frame.
        step(1, BL, 0);
        for (int f = 0; f < 8; f++) begin
            val = (f % 2 == 1) ? 57 : 13;
            step(0, enc[val % 10], 0);
            step(0, enc[val / 10], 1);
            check("alt_n1_valid", {11'd0, valid1}, 12'd1);
            check("alt_n1_value", {4'd0, ten1, unit1}, {4'd0, 4'(val / 10), 4'(val % 10)});
        end

        // Randomized mostly-conformant stream with glitches, bad glyphs and resets.
        nextd = 0;
        val   = 42;
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(99) == 0);
            d   = nextd;
            if ($urandom_range(19) == 0) d = 1 - d;
            if (d == 0 && $urandom_range(9) < 3) begin
                case ($urandom_range(5))
                    0: val = 42;
                    1: val = 96;
                    2: val = 13;
                    3: val = 57;
                    4: val = 0;
                    default: val = 88;
                endcase
            end
            seg = (d == 1) ? enc[val / 10] : enc[val % 10];
            if ($urandom_range(24) == 0) seg = 7'($urandom);
            step(rst, seg, d[0]);
            nextd = 1 - d;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
